// File: rtl/eot_pkg.sv
// Shared types for the eot-terminated transaction path (chop and release stages).
package eot_pkg;

  localparam int unsigned DEF_W_DATA = 16;
  localparam int unsigned EOT_POS    = DEF_W_DATA;

  // {eot, data} item as carried on the chop output and the release pred input
  typedef struct packed {
    logic                  eot;
    logic [DEF_W_DATA-1:0] data;
  } eot_data_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/eot_chop.sv
// eot_chop: takes a length N on cfg, passes exactly N din items to dout and
// marks the last one with eot. Datapath is a zero-latency pass-through; the
// only state is the FSM and the remaining-item counter.
module eot_chop
  import eot_pkg::*;
#(
  parameter int unsigned W_DATA = 16,
  parameter int unsigned W_CNT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [W_CNT-1:0]  cfg_data,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [W_DATA-1:0] din_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [W_DATA:0]   dout_data
);

  typedef struct packed {
    logic              eot;
    logic [W_DATA-1:0] data;
  } item_t;

  state_t             state;
  logic [W_CNT-1:0]   remaining;
  logic               last;
  logic               din_hs;
  logic               cfg_hs;
  logic               cfg_nonzero;
  item_t              out_item;

  // remaining is 0 outside RUN, so eot can only be set on a live last item
  assign last        = (remaining == W_CNT'(1));
  assign cfg_hs      = cfg_valid && cfg_ready;
  assign cfg_nonzero = (cfg_data != '0);
  assign din_hs      = (state == RUN) && din_valid && dout_ready;
  assign dout_data   = out_item;

  // Handshake steering: cfg accepted in IDLE, or in RUN only alongside the final item
  always_comb begin
    cfg_ready     = 1'b0;
    din_ready     = 1'b0;
    dout_valid    = 1'b0;
    out_item.eot  = last;
    out_item.data = din_data;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
      end
      RUN: begin
        dout_valid = din_valid;
        din_ready  = dout_ready;
        cfg_ready  = last && din_valid && dout_ready;
      end
      default: begin
        cfg_ready = 1'b1;
      end
    endcase
  end

  // Transaction FSM and length counter; a cfg taken with the last item reloads without a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_hs && cfg_nonzero) begin
            remaining <= cfg_data;
            state     <= RUN;
          end
        end
        RUN: begin
          if (din_hs) begin
            if (!last) begin
              remaining <= remaining - W_CNT'(1);
            end else if (cfg_hs && cfg_nonzero) begin
              remaining <= cfg_data;
            end else begin
              remaining <= '0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          remaining <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eot_chop.sv
// Scoreboard bench for eot_chop: transactions are expanded into expected
// {eot,data} items when issued; a monitor pops and compares on each dout handshake.
`timescale 1ns/1ps
module tb_eot_chop;

  localparam int W_DATA = 16;
  localparam int W_CNT  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_valid, cfg_ready;
  logic [W_CNT-1:0]  cfg_data;
  logic              din_valid, din_ready;
  logic [W_DATA-1:0] din_data;
  logic              dout_valid, dout_ready;
  logic [W_DATA:0]   dout_data;

  eot_chop #(.W_DATA(W_DATA), .W_CNT(W_CNT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_data   (din_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [W_DATA:0]   exp_q[$];
  logic [W_CNT-1:0]  cfg_q[$];
  logic [W_DATA-1:0] din_q[$];
  int                hs_cyc[$];

  int   cfg_rate  = 100;
  int   din_rate  = 100;
  int   stall_pct = 0;
  logic cfg_hs    = 1'b0;
  logic din_hs    = 1'b0;
  int   cyc       = 0;
  int   out_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a length-n transaction is n items, eot only on the final one
  task automatic add_txn(input int n, input logic [W_DATA-1:0] base, input bit rnd);
    logic [W_DATA-1:0] d;
    cfg_q.push_back(W_CNT'(n));
    for (int i = 0; i < n; i++) begin
      d = rnd ? W_DATA'($urandom) : base + W_DATA'(i);
      din_q.push_back(d);
      exp_q.push_back({(i == n - 1), d});
    end
  endtask

  // One cycle of the cfg/din/ready drivers; handshakes are sampled before the rising edge
  task automatic step();
    @(negedge clk);
    if (cfg_hs) begin void'(cfg_q.pop_front()); cfg_valid = 1'b0; end
    if (din_hs) begin void'(din_q.pop_front()); din_valid = 1'b0; end
    if (!cfg_valid && cfg_q.size() > 0 && int'($urandom_range(0, 99)) < cfg_rate) begin
      cfg_valid = 1'b1;
      cfg_data  = cfg_q[0];
    end
    if (!din_valid && din_q.size() > 0 && int'($urandom_range(0, 99)) < din_rate) begin
      din_valid = 1'b1;
      din_data  = din_q[0];
    end
    dout_ready = (int'($urandom_range(0, 99)) >= stall_pct);
    #1;
    cfg_hs = cfg_valid && cfg_ready;
    din_hs = din_valid && din_ready;
  endtask

  task automatic drain(input string name, input int budget);
    int left;
    left = budget;
    while ((cfg_q.size() > 0 || din_q.size() > 0 || exp_q.size() > 0 || cfg_valid || din_valid)
           && left > 0) begin
      step();
      left--;
    end
    vectors++;
    if (left == 0) begin
      miscompares++;
      $display("FAIL %s_timeout: %0d items outstanding, expected 0", name, exp_q.size());
    end
  endtask

  // Monitor: pops the scoreboard on each dout handshake and checks stall stability
  initial begin
    logic [W_DATA:0] prev_data;
    logic            stalled;
    logic [W_DATA:0] e;
    stalled   = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        if (stalled) begin
          check("stall_valid_hold", dout_valid, 1);
          check("stall_data_hold", dout_data, prev_data);
        end
        if (dout_valid) check("din_ready_mirror", din_ready, dout_ready);
        if (dout_valid && dout_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL dout_unexpected: got 0x%0h, expected no item", dout_data);
          end else begin
            e = exp_q.pop_front();
            check("dout_item", dout_data, e);
          end
          out_count++;
          hs_cyc.push_back(cyc);
        end
        stalled   = dout_valid && !dout_ready;
        prev_data = dout_data;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int guard;
    cfg_valid  = 1'b0;
    cfg_data   = '0;
    din_valid  = 1'b0;
    din_data   = '0;
    dout_ready = 1'b0;
    rst        = 1'b0;
    #1;
    check("reset_cfg_ready", cfg_ready, 1);
    check("reset_din_ready", din_ready, 0);
    check("reset_dout_valid", dout_valid, 0);
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;

    // Basic 4-item transaction
    add_txn(4, 16'h00A1, 0);
    drain("t_len4", 200);
    check("idle_cfg_ready", cfg_ready, 1);
    check("idle_din_ready", din_ready, 0);
    check("idle_dout_valid", dout_valid, 0);

    // Back-to-back 1 then 3 with no bubble
    hs_cyc.delete();
    add_txn(1, 16'h00B0, 0);
    add_txn(3, 16'h00B1, 0);
    drain("t_b2b", 200);
    check("b2b_count", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4) check("b2b_span", hs_cyc[3] - hs_cyc[0], 3);

    // Zero-length cfg then length 2
    hs_cyc.delete();
    add_txn(0, 16'h0000, 0);
    add_txn(2, 16'h00C0, 0);
    drain("t_zero", 200);
    check("zero_count", hs_cyc.size(), 2);

    // Backpressure
    stall_pct = 30;
    add_txn(8, 16'h0000, 1);
    drain("t_stall", 500);
    stall_pct = 0;

    // Maximum length for W_CNT=4
    hs_cyc.delete();
    add_txn(15, 16'h0F00, 0);
    drain("t_max", 500);
    check("max_count", hs_cyc.size(), 15);

    // Random transactions with random rates
    for (int t = 0; t < 25; t++) begin
      add_txn(int'($urandom_range(0, 15)), 16'h0000, 1);
    end
    cfg_rate  = int'($urandom_range(30, 100));
    din_rate  = int'($urandom_range(30, 100));
    stall_pct = int'($urandom_range(0, 50));
    drain("t_random", 20000);
    cfg_rate  = 100;
    din_rate  = 100;
    stall_pct = 0;

    // Asynchronous reset mid-transaction
    base = out_count;
    add_txn(5, 16'h00D0, 0);
    guard = 0;
    while (out_count < base + 2 && guard < 100) begin
      step();
      guard++;
    end
    check("rst_mid_reached", (out_count >= base + 2), 1);
    rst = 1'b0;
    #1;
    check("rst_mid_dout_valid", dout_valid, 0);
    check("rst_mid_din_ready", din_ready, 0);
    check("rst_mid_cfg_ready", cfg_ready, 1);
    exp_q.delete();
    din_q.delete();
    cfg_q.delete();
    cfg_valid = 1'b0;
    din_valid = 1'b0;
    cfg_hs    = 1'b0;
    din_hs    = 1'b0;
    @(negedge clk);
    #3 rst = 1'b1;

    // din offered while idle is not accepted
    din_valid = 1'b1;
    din_data  = 16'h0055;
    #1;
    check("idle_din_ignored", din_ready, 0);
    check("idle_dout_quiet", dout_valid, 0);
    @(negedge clk);
    #1;
    check("idle_din_ignored_2", din_ready, 0);
    din_valid = 1'b0;

    hs_cyc.delete();
    add_txn(2, 16'h00E0, 0);
    drain("t_after_rst", 200);
    check("after_rst_count", hs_cyc.size(), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
